// File: rtl/lwc_do_serializer.sv
// Output stage for the LWC core: buffers 32-bit result words and emits them MSB-first as
// W-bit beats. The final word of a segment is cut to its valid byte count.
module lwc_do_serializer #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [2:0]             in_bytes,
    output logic [W-1:0]           do_data,
    output logic                   do_valid,
    input  logic                   do_ready,
    output logic                   do_last,
    output logic [$clog2(DEPTH):0] fill
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned R  = 32 / W;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    if (!(W == 8 || W == 16 || W == 32)) begin : g_bad_w
        $error("lwc_do_serializer: W must be 8, 16 or 32");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("lwc_do_serializer: DEPTH must be a power of two, at least 2");
    end

    logic [31:0]   r_data  [DEPTH];
    logic          r_last  [DEPTH];
    logic [2:0]    r_bytes [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [1:0]    r_k;

    logic          w_push;
    logic          w_beat;
    logic          w_pop;
    logic [2:0]    w_bytes_eff;
    logic          w_head_last;
    logic [2:0]    w_head_bytes;
    int unsigned   w_beats;
    logic [1:0]    w_last_k;
    logic [31:0]   w_masked;
    logic [31:0]   w_shifted;

    assign in_ready = (r_count < DEPTH_W) && !rst;
    assign do_valid = (r_count != '0);
    assign fill     = r_count;

    assign w_push       = in_valid && in_ready;
    assign w_head_last  = r_last[r_rd_ptr];
    assign w_head_bytes = r_bytes[r_rd_ptr];

    // Out-of-range byte counts and non-last words both mean a full word.
    always_comb begin
        w_bytes_eff = 3'd4;
        if (in_last && in_bytes >= 3'd1 && in_bytes <= 3'd4) begin
            w_bytes_eff = in_bytes;
        end
    end

    always_comb begin
        w_beats = R;
        if (w_head_last) begin
            w_beats = (32'(w_head_bytes) * 8 + W - 1) / W;
        end
        w_last_k = 2'(w_beats - 1);
    end

    // Bytes past the valid count are zeroed before the beat is selected.
    always_comb begin
        w_masked = r_data[r_rd_ptr];
        for (int i = 0; i < 4; i++) begin
            if (3'(i) >= w_head_bytes) begin
                w_masked[31 - 8 * i -: 8] = 8'h00;
            end
        end
        w_shifted = w_masked << (32'(r_k) * W);
    end

    assign do_data = do_valid ? w_shifted[31 -: W] : '0;
    assign do_last = do_valid && w_head_last && (r_k == w_last_k);
    assign w_beat  = do_valid && do_ready;
    assign w_pop   = w_beat && (r_k == w_last_k);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_k      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW + 1)'(1);
            end
            if (w_beat) begin
                r_k <= w_pop ? 2'd0 : r_k + 2'd1;
            end
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wr_ptr]  <= in_data;
            r_last[r_wr_ptr]  <= in_last;
            r_bytes[r_wr_ptr] <= w_bytes_eff;
        end
    end

endmodule

// File: tb/tb_lwc_do_serializer.sv
// Directed bench for lwc_do_serializer: three instances (W=8, 16, 32; DEPTH=4) sharing one
// clock and reset, each scenario driven and checked by its own task.
module tb_lwc_do_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] a_data;  logic a_valid; logic a_ready; logic a_last; logic [2:0] a_bytes;
    logic [7:0]  a_do;    logic a_dv;    logic a_dr;    logic a_dl;   logic [2:0] a_fill;
    logic [31:0] b_data;  logic b_valid; logic b_ready; logic b_last; logic [2:0] b_bytes;
    logic [15:0] b_do;    logic b_dv;    logic b_dr;    logic b_dl;   logic [2:0] b_fill;
    logic [31:0] c_data;  logic c_valid; logic c_ready; logic c_last; logic [2:0] c_bytes;
    logic [31:0] c_do;    logic c_dv;    logic c_dr;    logic c_dl;   logic [2:0] c_fill;

    lwc_do_serializer #(.W(8), .DEPTH(4)) u8 (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .in_last(a_last), .in_bytes(a_bytes), .do_data(a_do), .do_valid(a_dv),
        .do_ready(a_dr), .do_last(a_dl), .fill(a_fill)
    );
    lwc_do_serializer #(.W(16), .DEPTH(4)) u16 (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .in_last(b_last), .in_bytes(b_bytes), .do_data(b_do), .do_valid(b_dv),
        .do_ready(b_dr), .do_last(b_dl), .fill(b_fill)
    );
    lwc_do_serializer #(.W(32), .DEPTH(4)) u32 (
        .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
        .in_last(c_last), .in_bytes(c_bytes), .do_data(c_do), .do_valid(c_dv),
        .do_ready(c_dr), .do_last(c_dl), .fill(c_fill)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        a_data = '0; a_valid = 0; a_last = 0; a_bytes = '0; a_dr = 0;
        b_data = '0; b_valid = 0; b_last = 0; b_bytes = '0; b_dr = 0;
        c_data = '0; c_valid = 0; c_last = 0; c_bytes = '0; c_dr = 0;
        rst = 1;
        tick(); tick();
        checks++;
        if ({a_dv, a_dl, a_do, a_fill, a_ready} !== '0) begin
            errors++;
            $display("FAIL reset_w8: got dv=%b dl=%b do=%h fill=%0d rdy=%b, want all 0",
                     a_dv, a_dl, a_do, a_fill, a_ready);
        end
        checks++;
        if ({b_dv, b_dl, b_do, b_fill, b_ready, c_dv, c_dl, c_do, c_fill, c_ready} !== '0) begin
            errors++;
            $display("FAIL reset_w16_w32: got b_dv=%b b_do=%h c_dv=%b c_do=%h, want 0",
                     b_dv, b_do, c_dv, c_do);
        end
        rst = 0;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 1", a_ready);
        end
    endtask

    task automatic test_w8_word;
        logic [7:0] exp [4];
        exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3; exp[3] = 8'hD4;
        a_dr = 1;
        a_valid = 1; a_data = 32'hA1B2C3D4; a_last = 1; a_bytes = 3'd4;
        tick();
        a_valid = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a_dv !== 1'b1 || a_do !== exp[i] || a_dl !== (i == 3)) begin
                errors++;
                $display("FAIL w8_beat%0d: got dv=%b do=%h dl=%b want dv=1 do=%h dl=%b",
                         i, a_dv, a_do, a_dl, exp[i], (i == 3));
            end
            tick();
        end
        checks++;
        if (a_dv !== 1'b0 || a_fill !== 3'd0) begin
            errors++;
            $display("FAIL w8_drain: got dv=%b fill=%0d want dv=0 fill=0", a_dv, a_fill);
        end
    endtask

    task automatic test_w16_truncate;
        logic [15:0] exp [4];
        exp[0] = 16'h1122; exp[1] = 16'h3344; exp[2] = 16'h5566; exp[3] = 16'h7700;
        b_dr = 1;
        b_valid = 1; b_data = 32'h11223344; b_last = 0; b_bytes = 3'd4;
        tick();
        b_data = 32'h55667788; b_last = 1; b_bytes = 3'd3;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b_dv !== 1'b1 || b_do !== exp[i] || b_dl !== (i == 3)) begin
                errors++;
                $display("FAIL w16_beat%0d: got dv=%b do=%h dl=%b want dv=1 do=%h dl=%b",
                         i, b_dv, b_do, b_dl, exp[i], (i == 3));
            end
            tick();
            b_valid = 0;
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (b_dv !== 1'b0) begin
                errors++;
                $display("FAIL w16_extra_beat: got dv=%b do=%h want dv=0", b_dv, b_do);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] w [5];
        w[0] = 32'h10000001; w[1] = 32'h20000002; w[2] = 32'h30000003;
        w[3] = 32'h40000004; w[4] = 32'h50000005;
        c_dr = 0;
        for (int i = 0; i < 4; i++) begin
            c_valid = 1; c_data = w[i]; c_last = 0; c_bytes = 3'd4;
            checks++;
            if (c_ready !== 1'b1) begin
                errors++;
                $display("FAIL w32_accept%0d: got in_ready=%b want 1", i, c_ready);
            end
            tick();
        end
        c_data = w[4]; c_last = 1; c_bytes = 3'd4;
        checks++;
        if (c_fill !== 3'd4 || c_ready !== 1'b0 || c_do !== w[0]) begin
            errors++;
            $display("FAIL w32_full: got fill=%0d rdy=%b do=%h want fill=4 rdy=0 do=%h",
                     c_fill, c_ready, c_do, w[0]);
        end
        tick();
        checks++;
        if (c_fill !== 3'd4 || c_ready !== 1'b0) begin
            errors++;
            $display("FAIL w32_held: got fill=%0d rdy=%b want fill=4 rdy=0", c_fill, c_ready);
        end
        c_dr = 1;
        tick();
        checks++;
        if (c_fill !== 3'd3 || c_ready !== 1'b1 || c_do !== w[1]) begin
            errors++;
            $display("FAIL w32_first_pop: got fill=%0d rdy=%b do=%h want fill=3 rdy=1 do=%h",
                     c_fill, c_ready, c_do, w[1]);
        end
        tick();
        c_valid = 0;
        checks++;
        if (c_fill !== 3'd3) begin
            errors++;
            $display("FAIL w32_push_pop: got fill=%0d want 3", c_fill);
        end
        for (int i = 2; i < 5; i++) begin
            checks++;
            if (c_dv !== 1'b1 || c_do !== w[i] || c_dl !== (i == 4)) begin
                errors++;
                $display("FAIL w32_word%0d: got dv=%b do=%h dl=%b want dv=1 do=%h dl=%b",
                         i, c_dv, c_do, c_dl, w[i], (i == 4));
            end
            tick();
        end
        checks++;
        if (c_dv !== 1'b0 || c_fill !== 3'd0) begin
            errors++;
            $display("FAIL w32_drain: got dv=%b fill=%0d want 0 0", c_dv, c_fill);
        end
    endtask

    task automatic test_stall;
        logic [7:0] exp [7];
        logic       rdy [7];
        // Beat 0 taken, beat 1 stalled twice, then beats 1..3 taken.
        exp[0] = 8'h0F; exp[1] = 8'h1E; exp[2] = 8'h1E; exp[3] = 8'h1E;
        exp[4] = 8'h2D; exp[5] = 8'h3C; exp[6] = 8'h00;
        rdy[0] = 1; rdy[1] = 0; rdy[2] = 0; rdy[3] = 1; rdy[4] = 1; rdy[5] = 1; rdy[6] = 1;
        a_dr = 1;
        a_valid = 1; a_data = 32'h0F1E2D3C; a_last = 1; a_bytes = 3'd4;
        tick();
        a_valid = 0;
        for (int i = 0; i < 7; i++) begin
            a_dr = rdy[i];
            checks++;
            if (a_dv !== (i < 6) || a_do !== exp[i] || a_dl !== (i == 5)) begin
                errors++;
                $display("FAIL stall_cyc%0d: got dv=%b do=%h dl=%b want dv=%b do=%h dl=%b",
                         i, a_dv, a_do, a_dl, (i < 6), exp[i], (i == 5));
            end
            tick();
        end
    endtask

    task automatic test_mid_reset;
        a_dr = 1;
        a_valid = 1; a_data = 32'h01020304; a_last = 0; a_bytes = 3'd4;
        tick();
        a_data = 32'h05060708; a_last = 1; a_bytes = 3'd4;
        tick();
        a_valid = 0;
        tick();
        checks++;
        if (a_do !== 8'h03 || a_fill !== 3'd2) begin
            errors++;
            $display("FAIL pre_reset: got do=%h fill=%0d want do=03 fill=2", a_do, a_fill);
        end
        rst = 1;
        #1;
        checks++;
        if (a_dv !== 1'b0 || a_fill !== 3'd0 || a_ready !== 1'b0 || a_do !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: got dv=%b fill=%0d rdy=%b do=%h want 0 0 0 00",
                     a_dv, a_fill, a_ready, a_do);
        end
        tick();
        rst = 0;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: got %b want 1", a_ready);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a_dv !== 1'b0 || a_dl !== 1'b0) begin
                errors++;
                $display("FAIL stale_beat%0d: got dv=%b do=%h want dv=0", i, a_dv, a_do);
            end
            tick();
        end
    endtask

    task automatic test_bytes_zero;
        c_dr = 1;
        c_valid = 1; c_data = 32'hDEADBEEF; c_last = 1; c_bytes = 3'd0;
        tick();
        c_valid = 0;
        checks++;
        if (c_dv !== 1'b1 || c_do !== 32'hDEADBEEF || c_dl !== 1'b1) begin
            errors++;
            $display("FAIL bytes0: got dv=%b do=%h dl=%b want 1 deadbeef 1", c_dv, c_do, c_dl);
        end
        tick();
        checks++;
        if (c_dv !== 1'b0) begin
            errors++;
            $display("FAIL bytes0_single: got dv=%b want 0", c_dv);
        end
        // W=32 with 2 valid bytes: one beat, low half zeroed.
        c_valid = 1; c_data = 32'hCAFEF00D; c_last = 1; c_bytes = 3'd2;
        tick();
        c_valid = 0;
        checks++;
        if (c_do !== 32'hCAFE0000 || c_dl !== 1'b1) begin
            errors++;
            $display("FAIL bytes2_w32: got do=%h dl=%b want cafe0000 1", c_do, c_dl);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_w8_word();
        test_w16_truncate();
        test_back_to_back();
        test_stall();
        test_mid_reset();
        test_bytes_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
